// File: rtl/magneton_sequencer_if.sv
// ============================================================================
// Module      : magneton_sequencer_if
// Description : Front-panel / magnetron bus for the cook-cycle sequencer.
//               master modport = panel side (drives buttons, door, tick, load)
//               slave  modport = sequencer side (drives mag_on, status, beep)
// Signals     : startn/stopn/clearn (active-low buttons), door_closed, tick,
//               load, time_in[TW], mag_on, timer_done, time_left[TW],
//               state[2], beep
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface magneton_sequencer_if #(
    parameter int TW = 12
);
    logic          startn;
    logic          stopn;
    logic          clearn;
    logic          door_closed;
    logic          tick;
    logic          load;
    logic [TW-1:0] time_in;
    logic          mag_on;
    logic          timer_done;
    logic [TW-1:0] time_left;
    logic [1:0]    state;
    logic          beep;

    modport master (
        output startn, stopn, clearn, door_closed, tick, load, time_in,
        input  mag_on, timer_done, time_left, state, beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, tick, load, time_in,
        output mag_on, timer_done, time_left, state, beep
    );
endinterface

`default_nettype wire

// File: rtl/magneton_sequencer.sv
// ============================================================================
// Module      : magneton_sequencer
// Description : Microwave cook-cycle controller. IDLE/COOK/PAUSE/DONE sequence
//               driven by active-low panel buttons, the door switch and a 1 Hz
//               tick; counts down the loaded cook time and enables the
//               magnetron.
// Ports       : clk    - system clock (rising edge)
//               resetn - asynchronous active-low reset
//               bus    - magneton_sequencer_if.slave (panel inputs, status out)
// Parameters  : TW         - cook-time counter width in seconds
//               BEEP_TICKS - ticks the beeper stays on after DONE entry
// Config      : MAGNETON_BEEP_EN - when defined, enables the DONE beeper;
//               otherwise beep is tied low and no counter exists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module magneton_sequencer #(
    parameter int TW         = 12,
    parameter int BEEP_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    magneton_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COOK  = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        st;
    logic [TW-1:0] time_left_r;
    logic          timer_done_r;

    // Two-stage button registers: first stage samples the pin, second holds
    // the previous sample so a press is a 1->0 edge of the registered value.
    logic start_q, start_d;
    logic stop_q,  stop_d;
    logic clear_q, clear_d;

    logic start_press, stop_press, clear_press;
    logic do_start, do_stop, do_clear;

    assign start_press = start_d & ~start_q;
    assign stop_press  = stop_d  & ~stop_q;
    assign clear_press = clear_d & ~clear_q;

    // Simultaneous presses resolve clear > stop > start.
    assign do_clear = clear_press;
    assign do_stop  = stop_press  & ~clear_press;
    assign do_start = start_press & ~stop_press & ~clear_press;

`ifdef MAGNETON_BEEP_EN
    localparam int BW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);
    logic          beep_r;
    logic [BW-1:0] beep_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st           <= S_IDLE;
            time_left_r  <= '0;
            timer_done_r <= 1'b0;
            start_q      <= 1'b1;
            start_d      <= 1'b1;
            stop_q       <= 1'b1;
            stop_d       <= 1'b1;
            clear_q      <= 1'b1;
            clear_d      <= 1'b1;
`ifdef MAGNETON_BEEP_EN
            beep_r       <= 1'b0;
            beep_cnt     <= '0;
`endif
        end else begin
            start_q <= bus.startn;
            start_d <= start_q;
            stop_q  <= bus.stopn;
            stop_d  <= stop_q;
            clear_q <= bus.clearn;
            clear_d <= clear_q;

            case (st)
                S_IDLE: begin
                    if (do_clear) begin
                        time_left_r <= '0;
                    end else if (do_start && bus.door_closed && (time_left_r != '0)) begin
                        st <= S_COOK;
                    end else if (bus.load) begin
                        time_left_r <= bus.time_in;
                    end
                end
                S_COOK: begin
                    if (do_clear) begin
                        st          <= S_IDLE;
                        time_left_r <= '0;
                    end else if (do_stop || !bus.door_closed) begin
                        // Pausing wins over a coincident tick: no decrement.
                        st <= S_PAUSE;
                    end else if (bus.tick) begin
                        if (time_left_r <= TW'(1)) begin
                            time_left_r  <= '0;
                            st           <= S_DONE;
                            timer_done_r <= 1'b1;
`ifdef MAGNETON_BEEP_EN
                            beep_r   <= (BEEP_TICKS > 0);
                            beep_cnt <= BW'(BEEP_TICKS);
`endif
                        end else begin
                            time_left_r <= time_left_r - TW'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (do_clear || do_stop) begin
                        st          <= S_IDLE;
                        time_left_r <= '0;
                    end else if (do_start && bus.door_closed) begin
                        st <= S_COOK;
                    end
                end
                S_DONE: begin
                    if (clear_press || stop_press || start_press || !bus.door_closed) begin
                        st           <= S_IDLE;
                        timer_done_r <= 1'b0;
`ifdef MAGNETON_BEEP_EN
                        beep_r <= 1'b0;
`endif
                    end
`ifdef MAGNETON_BEEP_EN
                    else if (bus.tick && beep_r) begin
                        if (beep_cnt <= BW'(1)) begin
                            beep_r <= 1'b0;
                        end
                        beep_cnt <= beep_cnt - BW'(1);
                    end
`endif
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // Combinational so an opening door kills the magnetron in the same cycle.
    assign bus.mag_on     = (st == S_COOK) & bus.door_closed;
    assign bus.timer_done = timer_done_r;
    assign bus.time_left  = time_left_r;
    assign bus.state      = st;
`ifdef MAGNETON_BEEP_EN
    assign bus.beep       = beep_r;
`else
    assign bus.beep       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_magneton_sequencer.sv
// ============================================================================
// Module      : tb_magneton_sequencer
// Description : Directed self-checking bench for magneton_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magneton_sequencer;

    localparam int TW = 12;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    magneton_sequencer_if #(.TW(TW)) bus ();

    magneton_sequencer #(.TW(TW), .BEEP_TICKS(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [TW-1:0] v);
        @(negedge clk);
        bus.load    = 1'b1;
        bus.time_in = v;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    // One-cycle press of any combination; returns at the negedge after the
    // resulting state change.
    task automatic press(input logic s, input logic p, input logic c);
        @(negedge clk);
        bus.startn = ~s;
        bus.stopn  = ~p;
        bus.clearn = ~c;
        @(negedge clk);
        bus.startn = 1'b1;
        bus.stopn  = 1'b1;
        bus.clearn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", bus.state); end
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL reset_time got %0d exp 0", bus.time_left); end
        checks++; if (bus.timer_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.timer_done); end
        checks++; if (bus.mag_on !== 1'b0) begin errors++; $display("FAIL reset_mag got %b exp 0", bus.mag_on); end
        checks++; if (bus.beep !== 1'b0) begin errors++; $display("FAIL reset_beep got %b exp 0", bus.beep); end
    endtask

    task automatic test_cook_cycle();
        do_load(12'd3);
        checks++; if (bus.time_left !== 12'd3) begin errors++; $display("FAIL load3 got %0d exp 3", bus.time_left); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL cook_state got %b exp 01", bus.state); end
        checks++; if (bus.mag_on !== 1'b1) begin errors++; $display("FAIL cook_mag got %b exp 1", bus.mag_on); end
        do_tick();
        checks++; if (bus.time_left !== 12'd2) begin errors++; $display("FAIL tick1 got %0d exp 2", bus.time_left); end
        do_tick();
        checks++; if (bus.time_left !== 12'd1) begin errors++; $display("FAIL tick2 got %0d exp 1", bus.time_left); end
        do_tick();
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL tick3 got %0d exp 0", bus.time_left); end
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL done_state got %b exp 11", bus.state); end
        checks++; if (bus.timer_done !== 1'b1) begin errors++; $display("FAIL done_flag got %b exp 1", bus.timer_done); end
        checks++; if (bus.mag_on !== 1'b0) begin errors++; $display("FAIL done_mag got %b exp 0", bus.mag_on); end
        // Extra tick in DONE must not wrap the counter.
        do_tick();
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL no_wrap got %0d exp 0", bus.time_left); end
        // Door opening leaves DONE.
        @(negedge clk); bus.door_closed = 1'b0;
        @(negedge clk); bus.door_closed = 1'b1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL done_door_exit got %b exp 00", bus.state); end
        checks++; if (bus.timer_done !== 1'b0) begin errors++; $display("FAIL done_clear got %b exp 0", bus.timer_done); end
    endtask

    task automatic test_door_pause();
        do_load(12'd5);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL dp_cook got %b exp 01", bus.state); end
        @(negedge clk);
        bus.door_closed = 1'b0;
        bus.tick        = 1'b1;
        #1;
        checks++; if (bus.mag_on !== 1'b0) begin errors++; $display("FAIL dp_mag_comb got %b exp 0", bus.mag_on); end
        @(negedge clk);
        bus.tick = 1'b0;
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL dp_pause got %b exp 10", bus.state); end
        checks++; if (bus.time_left !== 12'd5) begin errors++; $display("FAIL dp_hold got %0d exp 5", bus.time_left); end
        // Start with door open and a tick while paused are both ignored.
        press(1'b1, 1'b0, 1'b0);
        do_tick();
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL dp_open_start got %b exp 10", bus.state); end
        checks++; if (bus.time_left !== 12'd5) begin errors++; $display("FAIL dp_pause_tick got %0d exp 5", bus.time_left); end
        bus.door_closed = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL dp_resume got %b exp 01", bus.state); end
        do_tick();
        checks++; if (bus.time_left !== 12'd4) begin errors++; $display("FAIL dp_resume_tick got %0d exp 4", bus.time_left); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.state !== 2'b00 || bus.time_left !== 12'd0) begin errors++; $display("FAIL dp_clear got %b/%0d exp 00/0", bus.state, bus.time_left); end
    endtask

    task automatic test_zero_time();
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b00 || bus.mag_on !== 1'b0) begin errors++; $display("FAIL zero_start got %b/%b exp 00/0", bus.state, bus.mag_on); end
        do_load(12'd0);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL load0_start got %b exp 00", bus.state); end
        // Clear in IDLE wipes a loaded time.
        do_load(12'd8);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL idle_clear got %0d exp 0", bus.time_left); end
    endtask

    task automatic test_priority();
        do_load(12'd9);
        press(1'b1, 1'b0, 1'b0);
        do_load(12'd2);
        checks++; if (bus.time_left !== 12'd9) begin errors++; $display("FAIL cook_load_ign got %0d exp 9", bus.time_left); end
        press(1'b1, 1'b1, 1'b1);
        checks++; if (bus.state !== 2'b00 || bus.time_left !== 12'd0) begin errors++; $display("FAIL all3 got %b/%0d exp 00/0", bus.state, bus.time_left); end
        do_load(12'd4);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++; if (bus.state !== 2'b10 || bus.time_left !== 12'd4) begin errors++; $display("FAIL stop_wins got %b/%0d exp 10/4", bus.state, bus.time_left); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (bus.state !== 2'b00 || bus.time_left !== 12'd0) begin errors++; $display("FAIL pause_stop got %b/%0d exp 00/0", bus.state, bus.time_left); end
    endtask

    task automatic test_held_button();
        logic [1:0] prev;
        int         trans;
        do_load(12'd6);
        @(negedge clk); bus.startn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL held_start got %b exp 01", bus.state); end
        press(1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL held_no_resume got %b exp 10", bus.state); end
        bus.startn = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        // DONE, then hold start for 10 cycles: one exit, no restart.
        do_load(12'd1);
        press(1'b1, 1'b0, 1'b0);
        do_tick();
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL hold_done got %b exp 11", bus.state); end
`ifdef MAGNETON_BEEP_EN
        checks++; if (bus.beep !== 1'b1) begin errors++; $display("FAIL beep_on got %b exp 1", bus.beep); end
        do_tick();
        do_tick();
        checks++; if (bus.beep !== 1'b1) begin errors++; $display("FAIL beep_2 got %b exp 1", bus.beep); end
        do_tick();
        checks++; if (bus.beep !== 1'b0) begin errors++; $display("FAIL beep_3 got %b exp 0", bus.beep); end
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL beep_state got %b exp 11", bus.state); end
`endif
        do_load(12'd5);
        @(negedge clk); bus.startn = 1'b0;
        prev  = bus.state;
        trans = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.state !== prev) trans++;
            prev = bus.state;
        end
        bus.startn = 1'b1;
        checks++; if (trans !== 1) begin errors++; $display("FAIL hold_trans got %0d exp 1", trans); end
        checks++; if (bus.state !== 2'b00 || bus.timer_done !== 1'b0) begin errors++; $display("FAIL hold_idle got %b/%b exp 00/0", bus.state, bus.timer_done); end
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL done_load_ign got %0d exp 0", bus.time_left); end
    endtask

    task automatic test_async_reset();
        do_load(12'd7);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (bus.state !== 2'b01 || bus.time_left !== 12'd7) begin errors++; $display("FAIL pre_rst got %b/%0d exp 01/7", bus.state, bus.time_left); end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL arst_state got %b exp 00", bus.state); end
        checks++; if (bus.time_left !== 12'd0) begin errors++; $display("FAIL arst_time got %0d exp 0", bus.time_left); end
        checks++; if (bus.mag_on !== 1'b0) begin errors++; $display("FAIL arst_mag got %b exp 0", bus.mag_on); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        resetn          = 1'b0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;
        bus.tick        = 1'b0;
        bus.load        = 1'b0;
        bus.time_in     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_cook_cycle();
        test_door_pause();
        test_zero_time();
        test_priority();
        test_held_button();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
